// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// One 1-bit full adder is reused once per RUN cycle, LSB first, so a
// WIDTH-bit addition takes WIDTH cycles in RUN plus one cycle in DONE.
// S and Cout are registered and only change on the edge entering DONE.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic fa_sum;
  logic fa_carry;

  // The single shared full adder works on the current LSBs and carry.
  assign fa_sum   = a_sr[0] ^ b_sr[0] ^ carry;
  assign fa_carry = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

  // Control FSM and datapath registers; busy/done are registered Moore outputs.
  // NOTE: every register here uses <= so all of them see pre-edge values,
  // which is what makes the shift registers and the counter behave as one step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      Cout  <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= A;
            b_sr  <= B;
            carry <= Cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          s_sr  <= {fa_sum, s_sr[WIDTH-1:1]};
          carry <= fa_carry;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            // The final sum bit lands in the MSB in the same edge as the
            // complete word is published.
            S     <= {fa_sum, s_sr[WIDTH-1:1]};
            Cout  <= fa_carry;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range WIDTH >= 2.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset; it SHALL be synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, the request to begin an addition, sampled only in IDLE.
REQ-005 The block SHALL have port A, input, WIDTH, operand A, captured on accepted start.
REQ-006 The block SHALL have port B, input, WIDTH, operand B, captured on accepted start.
REQ-007 The block SHALL have port Cin, input, 1, the initial carry, captured on accepted start.
REQ-008 The block SHALL have port busy, output, 1, high while a bit-serial addition is in progress.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port S, output, WIDTH, the registered sum.
REQ-011 The block SHALL have port Cout, output, 1, the registered final carry.

Function
REQ-012 The block SHALL sequence one 1-bit full-adder datapath (sum = a^b^c, carry = ab|ac|bc), using it once per RUN cycle, LSB first.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE with start=1 at edge 0, the block SHALL capture A, B into operand shift registers, load the carry register from Cin, clear the bit counter and enter RUN.
REQ-015 In IDLE with start=0, the block SHALL remain in IDLE with all registers unchanged.
REQ-016 In RUN at edge i+1 (i = 0..WIDTH-1), the block SHALL add operand bit i, operand bit i and the carry register, shift the sum bit into the internal sum shift register, load the carry register with the adder carry, right-shift both operand registers and increment the counter.
REQ-017 At the RUN edge that processes bit WIDTH-1 (edge WIDTH), the block SHALL load S with the complete sum and Cout with that bit's carry, then enter DONE.
REQ-018 The block SHALL remain in DONE for exactly one cycle and then return to IDLE unconditionally.
REQ-019 busy SHALL equal 1 exactly in RUN, for WIDTH cycles per operation; done SHALL equal 1 exactly in DONE (Moore outputs).
REQ-020 Latency SHALL be fixed: start sampled at edge 0 gives done high between edge WIDTH and edge WIDTH+1, independent of operand values.
REQ-021 S and Cout SHALL change only at the edge entering DONE or on reset; they SHALL hold the last result through IDLE and the following RUN.
REQ-022 start SHALL be ignored in RUN and DONE; the earliest next accepted start SHALL be the first IDLE cycle after DONE.
REQ-023 Changes on A, B or Cin outside the accepting IDLE edge SHALL NOT affect the result in progress.
REQ-024 The result SHALL satisfy {Cout,S} = A + B + Cin modulo 2^(WIDTH+1) for all inputs, with no saturation.

Reset
REQ-025 With rst=1 at an edge, the block SHALL enter IDLE and clear busy, done, S, Cout, the carry, counter and shift registers to 0, in any state.
REQ-026 If rst=1 occurs mid-RUN, the block SHALL discard the operation and raise no done; if rst and start are both 1, rst SHALL win.

Verification
REQ-027 WIDTH=8, A=8'h00, B=8'h00, Cin=0, start at edge 0 -> busy during edges 0..8, done high after edge 8, S=8'h00 and Cout=0.
REQ-028 WIDTH=8, A=8'hFF, B=8'h01, Cin=0 -> S=8'h00 and Cout=1; A=8'hFF, B=8'hFF, Cin=1 -> S=8'hFF and Cout=1.
REQ-029 WIDTH=8, A=8'h5A, B=8'hA5, Cin=1, with A/B/Cin changed to random values during RUN -> S=8'h00 and Cout=1.
REQ-030 start held high continuously for 30 cycles -> exactly one done every WIDTH+2 cycles, and each result matches the operands present at its accepting edge.
REQ-031 rst=1 at RUN cycle 4 -> next cycle busy=0, done=0, S=0 and Cout=0; no done pulse follows; a new start then completes normally.
REQ-032 WIDTH=3, exhaustive sweep of all 128 (A,B,Cin) combinations -> every {Cout,S} equals A+B+Cin with done latency 3.
